perf_cntr_bank: RTL and testbench
=================================

Name: perf_cntr_bank

Overview:
- Multi-channel performance counter bank on the CPU data bus (dbus_addr[30] region); next generation of the single 64-bit cycle counter.
- Provides NUM_CNTRS independent counters of parametrised width. Each counter has its own mode: clear, count cycles, hold, or count an external event line.
- Adds an atomic 64-bit read via a high-word shadow, sticky overflow flags, and a global broadcast control word for starting/stopping all counters in the same cycle.

Parameters:
- NUM_CNTRS, 4, number of counter channels; legal range 1..15.
- CNT_WIDTH, 64, counter width in bits; legal range 33..64; HI word zero-extended.
- ADDR_WIDTH, 8, byte-address bits decoded; need 4*(NUM_CNTRS+1) words to fit in 2^(ADDR_WIDTH-2).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- addr_i  input  ADDR_WIDTH  byte address; word index = addr_i[ADDR_WIDTH-1:2]
- we_i  input  1  write strobe (already qualified by region decode)
- wdata_i  input  32  write data
- re_i  input  1  read strobe (load in progress); needed for snapshot side effect
- event_i  input  NUM_CNTRS  per-channel event levels, synchronous to clk_i
- rdata_o  output  32  registered read data

Behaviour:
- Reset: all counters 0, all modes 0 (CLEAR), all shadows 0, all ovf 0, rdata_o 0.
- Modes (2 bits, encoding matches the legacy counter):
  - 0 CLEAR: counter <= 0 every cycle.
  - 1 CYCLE: counter +1 every cycle.
  - 2 HOLD: counter frozen.
  - 3 EVENT: counter +1 in each cycle where event_i[k]=1.
- Register map (word index):
  - 0 GLOBAL: write mode = wdata_i[1:0] to every channel; read = {zero-pad, ovf[NUM_CNTRS-1:0]}.
  - 1..3: reserved.
  - 4+4k CTRL_k: rw, mode in [1:0], rest reads 0.
  - 5+4k LO_k: read = counter[31:0]; also shadow_k <= counter[CNT_WIDTH-1:32] in the same cycle.
  - 6+4k HI_k: read = shadow_k (zero-extended); writes ignored.
  - 7+4k OVF_k: read = {31'b0, ovf_k}; write with wdata_i[0]=1 clears ovf_k.
- Unmapped or out-of-range words read 0 and ignore writes.
- Read latency: one cycle. rdata_o is valid the cycle after re_i; it holds its value when re_i=0.
- Read value is the register content at the cycle of re_i, i.e. the pre-increment value. LO and the shadow capture are taken from the same value, so a LO then HI read yields a coherent 64-bit sample.
- Write timing: a mode write takes effect the next cycle; the increment in the write cycle uses the old mode.
- Write to GLOBAL and CTRL_k in the same cycle cannot occur (single address). GLOBAL updates all channels in the same cycle, so they stay cycle-aligned.
- Wrap: a counter at all-ones that increments goes to 0 and sets ovf_k sticky. If a clear-write and a wrap land in the same cycle, set wins.
- CLEAR mode does not clear ovf_k or shadow_k.
- we_i and re_i on the same word in the same cycle: the write is performed and the read returns the old value.
- rst_i asserted mid-count or between a LO and HI read: everything returns to its reset values on that edge; a subsequent HI read returns 0.
- Read mux is registered and has no combinational path from addr_i to rdata_o.

Decomposition:
- Shared package perf_pkg:
  - Mode localparams MODE_CLEAR/MODE_CYCLE/MODE_HOLD/MODE_EVENT.
  - Register word offsets (GLOBAL=0, CH_BASE=4, OFF_CTRL=0, OFF_LO=1, OFF_HI=2, OFF_OVF=3).
  - Mode width constant 2.
- Sub-module perf_cntr_chan, one channel:
  - Contains mode register, CNT_WIDTH counter, shadow, and ovf.
  - Inputs: mode_we/mode_wdata, lo_rd, ovf_clr, event.
  - Outputs: cnt, shadow, ovf.
- Top instantiates NUM_CNTRS channels via generate and owns the address decode and registered read mux.

Test Plan:
- Reset, then read every mapped word -> all return 0, one cycle after re_i.
- Write CTRL_0=1, wait 10 cycles, write CTRL_0=2, read LO_0 -> 10 (±0, exact count from the write edge); a second read -> the same value (HOLD).
- CTRL_1=3, drive event_i[1] high on 7 non-consecutive cycles -> LO_1=7. Channel 0 in CLEAR throughout -> LO_0=0.
- CNT_WIDTH=64, counter preloaded near 0x0000_0000_FFFF_FFFE in CYCLE: read LO at 0xFFFFFFFF, then HI -> HI=0 (shadow), even though the live counter has crossed to 0x1_0000_0000.
- CNT_WIDTH=33, counter at all-ones, CYCLE -> wraps to 0, OVF_k=1, GLOBAL bit k=1. Write OVF_k=1 on the same cycle as a second wrap -> ovf stays 1.
- GLOBAL write 1 with 4 channels, then GLOBAL write 2 -> all LO_k identical. Assert rst_i mid-run -> all reads 0 afterwards.

Source files
------------

// File: rtl/perf_cntr_bank_pkg.sv
// Shared constants for the performance counter bank: mode encodings and
// register word offsets.
package perf_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  // Encoding matches the legacy single cycle counter.
  localparam mode_t MODE_CLEAR = 2'd0;
  localparam mode_t MODE_CYCLE = 2'd1;
  localparam mode_t MODE_HOLD  = 2'd2;
  localparam mode_t MODE_EVENT = 2'd3;

  // Word offsets within the register map.
  localparam int unsigned REG_GLOBAL = 0;
  localparam int unsigned CH_BASE    = 4;
  localparam int unsigned OFF_CTRL   = 0;
  localparam int unsigned OFF_LO     = 1;
  localparam int unsigned OFF_HI     = 2;
  localparam int unsigned OFF_OVF    = 3;

  // Word index of register 'off' in channel k.
  function automatic int unsigned ch_word(int unsigned k, int unsigned off);
    return CH_BASE + 4 * k + off;
  endfunction

endpackage

// File: rtl/perf_cntr_bank_if.sv
// Data-bus slave port of the performance counter bank.
interface perf_cntr_bank_if #(
  parameter int unsigned ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  we_i;
  logic [31:0]           wdata_i;
  logic                  re_i;
  logic [31:0]           rdata_o;

  modport master (
    output addr_i,
    output we_i,
    output wdata_i,
    output re_i,
    input  rdata_o
  );

  modport slave (
    input  addr_i,
    input  we_i,
    input  wdata_i,
    input  re_i,
    output rdata_o
  );

endinterface

// File: rtl/perf_cntr_bank_chan.sv
// One counter channel: mode register, counter, high-word shadow and
// sticky overflow flag.
module perf_cntr_chan
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_we_i,
  input  mode_t                mode_wdata_i,
  input  logic                 lo_rd_i,
  input  logic                 ovf_clr_i,
  input  logic                 event_i,
  output mode_t                mode_o,
  output logic [31:0]          cnt_lo_o,
  output logic [CNT_WIDTH-33:0] shadow_o,
  output logic                 ovf_o
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  mode_t                mode_q, mode_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [HI_W-1:0]      shadow_q, shadow_d;
  logic                 ovf_q, ovf_d;
  logic                 inc;
  logic [CNT_WIDTH:0]   cnt_inc;

  // Next-state: count per current mode, capture shadow on LO read, track wrap.
  always_comb begin
    mode_d = mode_q;
    if (mode_we_i) begin
      mode_d = mode_wdata_i;
    end

    inc     = (mode_q == MODE_CYCLE) || ((mode_q == MODE_EVENT) && event_i);
    cnt_inc = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);

    if (mode_q == MODE_CLEAR) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_inc[CNT_WIDTH-1:0];
    end else begin
      cnt_d = cnt_q;
    end

    // A wrap in the same cycle as a clear request leaves the flag set.
    ovf_d = ovf_q;
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (inc && cnt_inc[CNT_WIDTH]) begin
      ovf_d = 1'b1;
    end

    shadow_d = shadow_q;
    if (lo_rd_i) begin
      shadow_d = cnt_q[CNT_WIDTH-1:32];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q   <= MODE_CLEAR;
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Output drive.
  always_comb begin
    mode_o   = mode_q;
    cnt_lo_o = cnt_q[31:0];
    shadow_o = shadow_q;
    ovf_o    = ovf_q;
  end

endmodule

// File: rtl/perf_cntr_bank.sv
// Multi-channel performance counter bank: address decode, channel array
// and registered read mux.
module perf_cntr_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNTRS  = 4,
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  perf_cntr_bank_if.slave      bus,
  input  logic [NUM_CNTRS-1:0] event_i
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned HI_W   = CNT_WIDTH - 32;

  logic [WORD_W-1:0]    word;
  logic                 glb_we;
  logic [NUM_CNTRS-1:0] mode_we, lo_rd, ovf_clr, ovf;
  mode_t                mode   [NUM_CNTRS];
  logic [31:0]          cnt_lo [NUM_CNTRS];
  logic [HI_W-1:0]      shadow [NUM_CNTRS];
  logic [31:0]          rdata_q, rdata_d;
  logic                 unused_bits;

  // Word decode into per-channel strobes; GLOBAL writes reach every channel.
  always_comb begin
    word        = bus.addr_i[ADDR_WIDTH-1:2];
    glb_we      = bus.we_i && (word == WORD_W'(REG_GLOBAL));
    unused_bits = ^{bus.addr_i[1:0], bus.wdata_i[31:2]};
    for (int unsigned k = 0; k < NUM_CNTRS; k++) begin
      mode_we[k] = glb_we || (bus.we_i && (word == WORD_W'(ch_word(k, OFF_CTRL))));
      lo_rd[k]   = bus.re_i && (word == WORD_W'(ch_word(k, OFF_LO)));
      ovf_clr[k] = bus.we_i && bus.wdata_i[0] && (word == WORD_W'(ch_word(k, OFF_OVF)));
    end
  end

  for (genvar k = 0; k < NUM_CNTRS; k++) begin : g_chan
    perf_cntr_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mode_we_i   (mode_we[k]),
      .mode_wdata_i(mode_t'(bus.wdata_i[MODE_W-1:0])),
      .lo_rd_i     (lo_rd[k]),
      .ovf_clr_i   (ovf_clr[k]),
      .event_i     (event_i[k]),
      .mode_o      (mode[k]),
      .cnt_lo_o    (cnt_lo[k]),
      .shadow_o    (shadow[k]),
      .ovf_o       (ovf[k])
    );
  end

  // Read mux: selects pre-update register contents; holds when idle.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.re_i) begin
      rdata_d = '0;
      if (word == WORD_W'(REG_GLOBAL)) begin
        rdata_d[NUM_CNTRS-1:0] = ovf;
      end
      for (int unsigned k = 0; k < NUM_CNTRS; k++) begin
        if (word == WORD_W'(ch_word(k, OFF_CTRL))) rdata_d = 32'(mode[k]);
        if (word == WORD_W'(ch_word(k, OFF_LO)))   rdata_d = cnt_lo[k];
        if (word == WORD_W'(ch_word(k, OFF_HI)))   rdata_d = 32'(shadow[k]);
        if (word == WORD_W'(ch_word(k, OFF_OVF)))  rdata_d = 32'(ovf[k]);
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Bus output drive.
  always_comb begin
    bus.rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_perf_cntr_bank.sv
// Bench for perf_cntr_bank: a 64-bit/4-channel and a 33-bit/2-channel
// instance share one stimulus stream and are checked every cycle against a
// behavioural register-map model, plus directed literal expectations.
module tb_perf_cntr_bank;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [7:0]  addr  = '0;
  logic        we    = 1'b0;
  logic        re    = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  ev    = '0;

  always #5 clk = ~clk;

  perf_cntr_bank_if #(.ADDR_WIDTH(8)) bus_a ();
  perf_cntr_bank_if #(.ADDR_WIDTH(8)) bus_b ();

  assign bus_a.addr_i  = addr;
  assign bus_a.we_i    = we;
  assign bus_a.wdata_i = wdata;
  assign bus_a.re_i    = re;
  assign bus_b.addr_i  = addr;
  assign bus_b.we_i    = we;
  assign bus_b.wdata_i = wdata;
  assign bus_b.re_i    = re;

  perf_cntr_bank #(.NUM_CNTRS(4), .CNT_WIDTH(64), .ADDR_WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus_a),
    .event_i(ev)
  );

  perf_cntr_bank #(.NUM_CNTRS(2), .CNT_WIDTH(33), .ADDR_WIDTH(8)) dut33 (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus_b),
    .event_i(ev[1:0])
  );

  // ---------------- behavioural model ----------------
  int unsigned     n_ch [2] = '{4, 2};
  longint unsigned msk  [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1_FFFF_FFFF};
  longint unsigned m_cnt  [2][4];
  longint unsigned m_sh   [2][4];
  logic [1:0]      m_mode [2][4];
  logic            m_ovf  [2][4];
  logic [31:0]     m_rd   [2];
  int              mw;
  logic            mbump, mwrap;

  // preload requests mirror the force applied to a DUT counter
  logic            pre_v   = 1'b0;
  int              pre_d   = 0;
  int              pre_k   = 0;
  longint unsigned pre_val = 0;

  logic        chk_en   = 1'b0;
  logic        lit_req  = 1'b0;
  int          lit_d    = 0;
  logic [31:0] lit_exp  = '0;
  string       lit_name = "";
  int          n_vec    = 0;
  int          n_err    = 0;

  function automatic logic [31:0] mread(int d, int w);
    logic [31:0] r;
    int k, o;
    r = '0;
    if (w == 0) begin
      for (int i = 0; i < int'(n_ch[d]); i++) r[i] = m_ovf[d][i];
    end else if (w >= 4) begin
      k = (w - 4) / 4;
      o = (w - 4) % 4;
      if (k < int'(n_ch[d])) begin
        case (o)
          0: r = {30'b0, m_mode[d][k]};
          1: r = 32'(m_cnt[d][k]);
          2: r = 32'(m_sh[d][k]);
          default: r = {31'b0, m_ovf[d][k]};
        endcase
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_rd[d] = '0;
        for (int k = 0; k < 4; k++) begin
          m_cnt[d][k] = 0; m_sh[d][k] = 0; m_mode[d][k] = 2'd0; m_ovf[d][k] = 1'b0;
        end
      end
    end else begin
      mw = int'(addr[7:2]);
      if (pre_v) m_cnt[pre_d][pre_k] = pre_val;
      for (int d = 0; d < 2; d++) begin
        if (re) m_rd[d] = mread(d, mw);
        for (int k = 0; k < int'(n_ch[d]); k++) begin
          if (re && mw == 5 + 4 * k) m_sh[d][k] = m_cnt[d][k] >> 32;
          mwrap = 1'b0;
          mbump = (m_mode[d][k] == 2'd1) || (m_mode[d][k] == 2'd3 && ev[k]);
          if (m_mode[d][k] == 2'd0) begin
            m_cnt[d][k] = 0;
          end else if (mbump) begin
            if (m_cnt[d][k] == msk[d]) begin
              m_cnt[d][k] = 0;
              mwrap = 1'b1;
            end else begin
              m_cnt[d][k] = m_cnt[d][k] + 1;
            end
          end
          if (we && mw == 7 + 4 * k && wdata[0]) m_ovf[d][k] = 1'b0;
          if (mwrap) m_ovf[d][k] = 1'b1;
          if (we && (mw == 0 || mw == 4 + 4 * k)) m_mode[d][k] = wdata[1:0];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] got;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      n_vec++;
      if (bus_a.rdata_o !== m_rd[0]) begin
        n_err++;
        $display("FAIL model_dut64 t=%0t: rdata=%h expected %h", $time, bus_a.rdata_o, m_rd[0]);
      end
      n_vec++;
      if (bus_b.rdata_o !== m_rd[1]) begin
        n_err++;
        $display("FAIL model_dut33 t=%0t: rdata=%h expected %h", $time, bus_b.rdata_o, m_rd[1]);
      end
      if (lit_req) begin
        got = (lit_d == 0) ? bus_a.rdata_o : bus_b.rdata_o;
        n_vec++;
        if (got !== lit_exp) begin
          n_err++;
          $display("FAIL %s dut%0d t=%0t: rdata=%h expected %h", lit_name, lit_d, $time, got, lit_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(int w, logic [31:0] d);
    addr = 8'(w * 4); wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(int w);
    addr = 8'(w * 4); re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic post(int d, logic [31:0] e, string name);
    lit_req = 1'b1; lit_d = d; lit_exp = e; lit_name = name;
    tick();
    lit_req = 1'b0;
  endtask

  task automatic rd_chk(int d, int w, logic [31:0] e, string name);
    rd(w);
    post(d, e, name);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state of every mapped word
    for (int w = 0; w < 20; w++) rd_chk(0, w, 32'h0, "rst_map64");
    for (int w = 0; w < 12; w++) rd_chk(1, w, 32'h0, "rst_map33");

    // CYCLE for exactly 10 edges, then HOLD
    wr(4, 32'd1);
    idle(9);
    wr(4, 32'd2);
    rd_chk(0, 5, 32'd10, "hold_lo0");
    rd_chk(0, 5, 32'd10, "hold_lo0_again");
    rd_chk(1, 5, 32'd10, "hold_lo0_33");
    rd_chk(0, 4, 32'd2, "ctrl0_readback");

    // EVENT on channel 1, channel 0 back to CLEAR
    wr(4, 32'd0);
    wr(8, 32'd3);
    for (int i = 0; i < 7; i++) begin
      ev[1] = 1'b1; tick();
      ev[1] = 1'b0; tick();
    end
    rd_chk(0, 9, 32'd7, "event_lo1");
    rd_chk(0, 5, 32'd0, "clear_lo0");
    rd_chk(1, 9, 32'd7, "event_lo1_33");

    // write and read the same word in one cycle returns the old value
    addr = 8'(16 * 4); wdata = 32'd2; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    post(0, 32'd0, "rw_same_cycle_old");
    rd_chk(0, 16, 32'd2, "ctrl3_new");

    // HI writes, reserved and out-of-range words
    wr(10, 32'hDEAD_BEEF);
    wr(1, 32'h3);
    rd_chk(0, 10, 32'h0, "hi_write_ignored");
    rd_chk(0, 1, 32'h0, "reserved_word");
    rd_chk(0, 20, 32'h0, "out_of_range64");
    rd_chk(1, 12, 32'h0, "out_of_range33");

    // coherent 64-bit sample across the 32-bit carry on channel 2
    wr(12, 32'd1);
    force dut.g_chan[2].u_chan.cnt_q = 64'h0000_0000_FFFF_FFFE;
    pre_v = 1'b1; pre_d = 0; pre_k = 2; pre_val = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.g_chan[2].u_chan.cnt_q;
    tick();
    pre_v = 1'b0;
    rd_chk(0, 13, 32'hFFFF_FFFF, "lo2_before_carry");
    rd_chk(0, 14, 32'h0, "hi2_shadow");
    rd(13);
    rd_chk(0, 14, 32'h1, "hi2_after_carry");

    // 33-bit wrap sets sticky overflow
    wr(4, 32'd1);
    force dut33.g_chan[0].u_chan.cnt_q = 33'h1_FFFF_FFFF;
    pre_v = 1'b1; pre_d = 1; pre_k = 0; pre_val = 64'h1_FFFF_FFFF;
    #1;
    release dut33.g_chan[0].u_chan.cnt_q;
    tick();
    pre_v = 1'b0;
    rd_chk(1, 7, 32'h1, "ovf0_33_set");
    rd_chk(1, 0, 32'h1, "global_ovf33");
    rd_chk(0, 0, 32'h0, "global_ovf64");
    wr(7, 32'h1);
    rd_chk(1, 7, 32'h0, "ovf0_33_cleared");

    // clear request coincident with a wrap: set wins
    addr = 8'(7 * 4); wdata = 32'h1; we = 1'b1;
    force dut33.g_chan[0].u_chan.cnt_q = 33'h1_FFFF_FFFF;
    pre_v = 1'b1; pre_d = 1; pre_k = 0; pre_val = 64'h1_FFFF_FFFF;
    #1;
    release dut33.g_chan[0].u_chan.cnt_q;
    tick();
    we = 1'b0; pre_v = 1'b0;
    rd_chk(1, 7, 32'h1, "ovf_set_wins");

    // GLOBAL broadcast keeps all channels cycle-aligned
    wr(0, 32'd0);
    wr(0, 32'd1);
    idle(4);
    wr(0, 32'd2);
    for (int k = 0; k < 4; k++) rd_chk(0, 5 + 4 * k, 32'd5, "global_lo64");
    for (int k = 0; k < 2; k++) rd_chk(1, 5 + 4 * k, 32'd5, "global_lo33");

    // reset mid-run, between a LO and HI read
    wr(0, 32'd1);
    idle(3);
    rd(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk(0, 6, 32'h0, "hi0_after_rst");
    for (int w = 0; w < 20; w++) rd_chk(0, w, 32'h0, "post_rst64");
    for (int w = 0; w < 12; w++) rd_chk(1, w, 32'h0, "post_rst33");

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
